// File: rtl/key_event_arbiter.sv
// Purpose: latches one-cycle key press pulses, grants them round-robin into an event FIFO.
// Latency: pulse sampled at edge E, grant in the following cycle, event visible after edge E+1.
// Backpressure: evt_ready stalls the FIFO head; when the FIFO is full, presses wait in pending and repeats coalesce (ovf).
//
// Ports:
//   clk, rst         single clock, synchronous active-high reset
//   key_pulse[15:0]  press pulses, bit i = key i, several may be high together
//   flush            synchronous clear of pending, FIFO, rr pointer and ovf
//   evt_ready        consumer accepts the head event
//   evt_valid        FIFO non-empty
//   evt_code[3:0]    key index of the head event (show-ahead), 0 while empty
//   pending[15:0]    keys latched but not yet queued
//   fifo_count[4:0]  number of queued events, 0..DEPTH
//   ovf              sticky: a press arrived for a key that was already pending

module key_event_arbiter #(
    parameter int DEPTH = 8    // power of two, 2..16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key_pulse,
    input  logic        flush,
    input  logic        evt_ready,
    output logic        evt_valid,
    output logic [3:0]  evt_code,
    output logic [15:0] pending,
    output logic [4:0]  fifo_count,
    output logic        ovf
);

    localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [3:0]       rr_ptr;
    logic [3:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    logic             grant_found;
    logic [3:0]       grant_idx;
    logic [3:0]       scan_idx;
    logic             grant;
    logic [15:0]      grant_onehot;
    logic             pop;

    // Round-robin search: first set pending bit at or above rr_ptr, wrapping 15->0.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = 4'd0;
        scan_idx    = 4'd0;
        for (int k = 0; k < 16; k++) begin
            scan_idx = rr_ptr + 4'(k);
            if (!grant_found && pending[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Full test uses the pre-edge count, so a same-cycle pop never frees a slot early.
    assign grant        = grant_found && (fifo_count < DEPTH_C) && !flush;
    assign grant_onehot = grant ? (16'h0001 << grant_idx) : 16'h0000;

    assign evt_valid = (fifo_count != 5'd0);
    assign evt_code  = evt_valid ? mem[rd_ptr] : 4'h0;
    assign pop       = evt_valid && evt_ready;

    // Storage needs no reset: contents are only observable through evt_valid.
    always_ff @(posedge clk) begin
        if (!rst && grant) begin
            mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pending    <= 16'h0000;
            rr_ptr     <= 4'd0;
            ovf        <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= 5'd0;
        end else begin
            // A new pulse on the key being granted keeps it pending (set wins).
            pending <= (pending & ~grant_onehot) | key_pulse;

            // Press on an already-pending key that is not leaving this cycle is lost.
            if (|(key_pulse & pending & ~grant_onehot)) begin
                ovf <= 1'b1;
            end

            if (grant) begin
                wr_ptr <= wr_ptr + 1'b1;
                rr_ptr <= grant_idx + 4'd1;
            end

            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({grant, pop})
                2'b10:   fifo_count <= fifo_count + 5'd1;
                2'b01:   fifo_count <= fifo_count - 5'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 Parameter DEPTH, default 8, event FIFO depth; SHALL be a power of two in the range 2..16.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 key_pulse  input  16  one-cycle press pulses, bit i = key i; several bits MAY be high in the same cycle.
REQ-005 flush  input  1  synchronous clear of pending bits, FIFO, pointer and overflow flag.
REQ-006 evt_ready  input  1  consumer accepts the head event.
REQ-007 evt_valid  output  1  FIFO non-empty, head event presented.
REQ-008 evt_code  output  4  key index of the head event, show-ahead.
REQ-009 pending  output  16  keys latched but not yet queued.
REQ-010 fifo_count  output  5  number of events stored, 0..DEPTH.
REQ-011 ovf  output  1  sticky flag: one or more presses were coalesced.

Function
REQ-012 Pending latch: pending[i] SHALL be set at the edge after key_pulse[i]=1 and cleared only when key i is granted or on flush/rst.
REQ-013 Set wins: if key_pulse[i]=1 in the same cycle key i is granted, pending[i] SHALL remain 1.
REQ-014 Grant condition: a grant SHALL occur in a cycle iff pending!=0, fifo_count<DEPTH and flush=0; at most one grant per cycle.
REQ-015 Grant selection: round-robin; the granted index is the first set pending bit scanning upward from rr_ptr and wrapping 15->0.
REQ-016 rr_ptr SHALL be 4 bits, reset to 0, and updated to (granted index + 1) mod 16 on each grant; it holds when there is no grant.
REQ-017 The granted index SHALL be written into the FIFO tail at the same edge that clears its pending bit.
REQ-018 Latency: key_pulse sampled at edge E -> pending set at E -> grant cycle -> evt_valid=1 after edge E+1, given an empty FIFO and no competing pending bits.
REQ-019 FIFO pop: when evt_valid=1 and evt_ready=1, the head SHALL be removed at the edge; evt_ready while empty SHALL be ignored and count SHALL NOT underflow.
REQ-020 Full: the full test SHALL use the pre-edge count, so no grant occurs when fifo_count=DEPTH even if a pop happens in the same cycle; the pending bits are held.
REQ-021 Simultaneous push and pop SHALL leave fifo_count unchanged and SHALL preserve order.
REQ-022 Overflow: if key_pulse[i]=1 while pending[i]=1 and key i is not granted in that cycle, ovf SHALL set; ovf clears only on flush or rst.
REQ-023 The FIFO SHALL preserve grant order; read and write pointers wrap modulo DEPTH.
REQ-024 Flush SHALL take priority over all same-cycle pulses, grants and pops: pending=0, FIFO empty, rr_ptr=0, ovf=0 at the next edge.
REQ-025 evt_code SHALL hold its value while evt_valid=1 and evt_ready=0.

Reset
REQ-026 After rst=1 at an edge: pending=0, fifo_count=0, evt_valid=0, evt_code=0, ovf=0, rr_ptr=0.
REQ-027 Reset asserted mid-operation SHALL discard all queued and pending events; key_pulse during reset SHALL be ignored.
REQ-028 The first grant SHALL be possible in the cycle after rst deasserts.

Verification
REQ-029 Single key: key_pulse=16'h0020 for one cycle, evt_ready=0 -> evt_valid=1 two edges later, evt_code=5, fifo_count=1, pending=0.
REQ-030 Round-robin: key_pulse=16'h8101 in one cycle, evt_ready=1 -> codes 0, 8, 15 on three consecutive cycles; rr_ptr ends at 0.
REQ-031 Wrap: rr_ptr=14 with pending bits 1 and 15 set -> grant order 15 then 1.
REQ-032 Full: DEPTH=8 and 10 distinct keys pulsed, evt_ready=0 -> fifo_count=8 and pending keeps 2 bits; one pop releases one grant on the next cycle.
REQ-033 Coalesce: pulse key 3 twice while full -> one pending bit, ovf=1; flush -> ovf=0, evt_valid=0, pending=0.
REQ-034 Flush priority: flush=1 with key_pulse=16'hFFFF and evt_ready=1 -> all state empty at the next edge, and pending stays 0.
